// File: rtl/display_serializer.sv
// Shifts six 7-segment digit bytes MSB-first into a 74HC595 chain, then pulses the latch.
// Optional DISPLAY_DP_EN adds the i_dp port that drives bit 7 of each digit byte.
module display_serializer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_start,
  input  logic [6:0] i_hours_msb,
  input  logic [6:0] i_hours_lsb,
  input  logic [6:0] i_minutes_msb,
  input  logic [6:0] i_minutes_lsb,
  input  logic [6:0] i_seconds_msb,
  input  logic [6:0] i_seconds_lsb,
`ifdef DISPLAY_DP_EN
  input  logic [5:0] i_dp,
`endif
  output logic       o_busy,
  output logic       o_done,
  output logic       o_serial_clk,
  output logic       o_serial_data,
  output logic       o_latch
);

  localparam int unsigned FRAME_W = 48;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  state_t             state;
  logic [FRAME_W-2:0] frame;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [5:0]         dp_c;
  logic [FRAME_W-1:0] frame_c;

`ifdef DISPLAY_DP_EN
  assign dp_c = i_dp;
`else
  assign dp_c = 6'b000000;
`endif

  // Bit 47 goes straight to o_serial_data on accept; the register keeps the rest.
  assign frame_c = {dp_c[5], i_hours_msb,   dp_c[4], i_hours_lsb,
                    dp_c[3], i_minutes_msb, dp_c[2], i_minutes_lsb,
                    dp_c[1], i_seconds_msb, dp_c[0], i_seconds_lsb};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      frame         <= '0;
      bit_cnt       <= '0;
      div_cnt       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_serial_clk  <= 1'b0;
      o_serial_data <= 1'b0;
      o_latch       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start && i_en) begin
            frame         <= frame_c[FRAME_W-2:0];
            bit_cnt       <= LAST_BIT;
            div_cnt       <= DIV_MAX;
            o_busy        <= 1'b1;
            o_serial_clk  <= 1'b0;
            o_serial_data <= frame_c[FRAME_W-1];
            state         <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (div_cnt == '0) begin
            div_cnt      <= DIV_MAX;
            o_serial_clk <= 1'b1;
            state        <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (div_cnt == '0) begin
            div_cnt      <= DIV_MAX;
            o_serial_clk <= 1'b0;
            if (bit_cnt == '0) begin
              o_serial_data <= 1'b0;
              o_latch       <= 1'b1;
              state         <= LATCH;
            end else begin
              bit_cnt       <= bit_cnt - BIT_W'(1);
              o_serial_data <= frame[FRAME_W-2];
              frame         <= {frame[FRAME_W-3:0], 1'b0};
              state         <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        LATCH: begin
          if (div_cnt == '0) begin
            div_cnt <= DIV_MAX;
            o_latch <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            state   <= DONE;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy        <= 1'b0;
          o_done        <= 1'b0;
          o_serial_clk  <= 1'b0;
          o_serial_data <= 1'b0;
          o_latch       <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/display_serializer.md
# display_serializer

Serial output stage for the digital clock: takes the six 7-segment digit patterns produced by the binary-to-7-segment conversion stage and shifts them into a chain of six 74HC595-style shift registers, then pulses the storage latch. It sits directly downstream of the 7-segment conversion and drives the board pins. A start/busy/done handshake lets the top level request one refresh per seconds tick.

## Interface

Parameters:
- CLK_DIV, default 4: serial clock half-period in i_clk cycles; legal range 1-255.

Ports:
- i_clk  input  1  system clock.
- i_reset_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- i_en  input  1  enable; when low, no new frame is accepted.
- i_start  input  1  refresh request, sampled each cycle.
- i_hours_msb, i_hours_lsb, i_minutes_msb, i_minutes_lsb, i_seconds_msb, i_seconds_lsb  input  7 each  segment patterns, bit 6 = seg g … bit 0 = seg a.
- i_dp  input  6  decimal-point bits, bit 5 = hours_msb … bit 0 = seconds_lsb. Present only when DISPLAY_DP_EN is defined.
- o_busy  output  1  frame in progress.
- o_done  output  1  one-cycle pulse when a frame completes.
- o_serial_clk  output  1  shift clock to the register chain.
- o_serial_data  output  1  serial data to the register chain.
- o_latch  output  1  storage-register latch pulse.

## Operation

- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE: if i_start && i_en, capture a 48-bit frame {hours_msb, hours_lsb, minutes_msb, minutes_lsb, seconds_msb, seconds_lsb}. Each byte is {dp, seg[6:0]}. Load the bit counter with 47 and go to SHIFT_LO.
- Frame order: MSB-first, so bit 47 (the hours_msb dp) is shifted out first.
- Inputs are snapshotted on the accept cycle only. Later input changes do not affect the frame in flight.
- SHIFT_LO: o_serial_clk=0 and o_serial_data=current bit, held for CLK_DIV cycles. Then go to SHIFT_HI.
- SHIFT_HI: o_serial_clk=1 and data held, for CLK_DIV cycles.
  - If the bit counter is 0, go to LATCH.
  - Otherwise decrement the counter, shift the frame left, and return to SHIFT_LO.
- LATCH: o_latch=1 and o_serial_clk=0 for CLK_DIV cycles, then go to DONE.
- DONE: o_done=1 for one cycle, then return to IDLE.
- o_busy=1 in SHIFT_LO, SHIFT_HI and LATCH. It is 0 in IDLE and DONE.
- i_start while busy or in DONE is ignored; it is not queued.
- i_en falling mid-frame does not abort. The frame completes normally, and further starts are blocked while i_en is low.
- o_serial_data is 0 in IDLE, LATCH and DONE.
- The divider counter is sized to hold CLK_DIV-1 and reloads at each state transition.

## Timing

- Reset (asynchronous assert; deassert synchronised by the system):
  - all outputs are 0;
  - FSM is in IDLE;
  - frame and counters are cleared.
- Reset mid-frame discards the partial frame with no latch pulse, so the displays keep their previous contents.
- Accept cycle N (i_start sampled high): o_busy=1 and the first SHIFT_LO begin at cycle N+1.
- Shift phase lasts 96·CLK_DIV cycles and the latch phase CLK_DIV cycles. o_busy is high for exactly 97·CLK_DIV cycles.
- o_done pulses at cycle N+1+97·CLK_DIV. The earliest next accept is the cycle after that pulse.
- Data is stable for a full CLK_DIV cycles before each rising edge of o_serial_clk and CLK_DIV cycles after it.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration

- DISPLAY_DP_EN defined:
  - the i_dp port exists;
  - byte bit 7 of each digit = the corresponding i_dp bit, captured with the frame.
- Not defined:
  - no i_dp port;
  - bit 7 of every byte is 0;
  - frame length and timing are unchanged (48 bits).

## Test plan

- Reset, then idle: all outputs 0. One i_start pulse with CLK_DIV=4 -> o_busy high for exactly 388 cycles, exactly 48 rising edges on o_serial_clk, one 4-cycle o_latch pulse, one o_done pulse.
- Digits 12:34:56 encoded as 7-seg (0x06,0x5B,0x4F,0x66,0x6D,0x7D), dp=0. Sampling o_serial_data on each o_serial_clk rising edge yields bytes 0x06,0x5B,0x4F,0x66,0x6D,0x7D in that order.
- i_start held high continuously -> back-to-back frames, each accepted on the cycle after o_done. Inputs changed mid-frame appear only in the next frame.
- i_en=0 with an i_start pulse -> no activity. i_en dropped at bit 20 of a frame -> the frame completes with all 48 bits and the latch pulse.
- Assert i_reset_n=0 at bit 30 -> all outputs 0 asynchronously, no o_latch pulse. After release, a new start produces a full, correct frame.
- DISPLAY_DP_EN defined, i_dp=6'b010100 -> the hours_lsb and minutes_lsb bytes have bit 7 set and all other bytes have bit 7 clear. CLK_DIV=1 -> o_busy lasts 97 cycles.
